// File: rtl/strum_controller.sv
// Strum sequencer: synchronizes and debounces the strum button, captures the fret,
// offers the note over valid/ready and decays its level until it ends or is muted.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | silent, waiting for a debounced strum rise
//   ISSUE | note offered to the tone generator, fret/level frozen
//   PLAY  | note sounding, level decays every DECAY_CYCLES cycles
module strum_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DECAY_CYCLES    = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        strum_raw,
  input  logic        mute,
  input  logic [16:0] frets,
  input  logic        note_ready,
  output logic        note_valid,
  output logic [4:0]  note_fret,
  output logic [3:0]  note_level,
  output logic        note_active
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DC_W = $clog2(DECAY_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, PLAY} state_t;

  state_t            state, state_n;
  logic              sync_a, strum_sync, strum_db, strum_db_q, strum_rise;
  logic [DB_W-1:0]   db_cnt;
  logic [DC_W-1:0]   decay_cnt, decay_cnt_n;
  logic [4:0]        fret_q, fret_n;
  logic [3:0]        level_q, level_n;
  logic [4:0]        fret_enc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a     <= 1'b0;
      strum_sync <= 1'b0;
      strum_db   <= 1'b0;
      strum_db_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync_a     <= strum_raw;
      strum_sync <= sync_a;
      strum_db_q <= strum_db;
      if (strum_sync == strum_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        strum_db <= strum_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign strum_rise = strum_db & ~strum_db_q;

  // Descending scan so the lowest set bit is the one that sticks.
  always_comb begin
    fret_enc = 5'd0;
    for (int i = 16; i >= 0; i--) begin
      if (frets[i]) fret_enc = 5'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      fret_q    <= 5'd0;
      level_q   <= 4'd0;
      decay_cnt <= '0;
    end else begin
      state     <= state_n;
      fret_q    <= fret_n;
      level_q   <= level_n;
      decay_cnt <= decay_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    fret_n      = fret_q;
    level_n     = level_q;
    decay_cnt_n = decay_cnt;
    if (mute) begin
      state_n     = IDLE;
      fret_n      = 5'd0;
      level_n     = 4'd0;
      decay_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (strum_rise) begin
            state_n = ISSUE;
            fret_n  = fret_enc;
            level_n = 4'd15;
          end
        end
        ISSUE: begin
          if (note_ready) begin
            state_n     = PLAY;
            decay_cnt_n = '0;
          end
        end
        PLAY: begin
          if (strum_rise) begin
            state_n     = ISSUE;
            fret_n      = fret_enc;
            level_n     = 4'd15;
            decay_cnt_n = '0;
          end else if (decay_cnt == DC_LAST) begin
            decay_cnt_n = '0;
            if (level_q == 4'd1) begin
              state_n = IDLE;
              fret_n  = 5'd0;
              level_n = 4'd0;
            end else begin
              level_n = level_q - 4'd1;
            end
          end else begin
            decay_cnt_n = decay_cnt + DC_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          fret_n  = 5'd0;
          level_n = 4'd0;
        end
      endcase
    end
  end

  assign note_valid  = (state == ISSUE);
  assign note_active = (state == PLAY);
  assign note_fret   = fret_q;
  assign note_level  = level_q;

endmodule
